// File: rtl/burst_cache_wb.sv
// burst_cache_wb: direct-mapped write-back data cache between the CPU load/store unit and
// the BurstRAM controller. One cache line equals one RAM burst. Dirty lines are written
// back with a write burst before the refill read burst.
// Optional hit/miss counters are built when BURST_CACHE_WB_STATS_EN is defined.
module burst_cache_wb #(
    parameter int unsigned ADDRESS_BITWIDTH        = 32,
    parameter int unsigned DATA_BITWIDTH           = 32,
    parameter int unsigned LINE_IX_BITWIDTH        = 2,
    parameter int unsigned RAM_DEPTH_BITWIDTH      = 8,
    parameter int unsigned RAM_BURST_DATA_COUNT    = 4,
    parameter int unsigned RAM_BURST_DATA_BITWIDTH = 64
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en,
    input  logic [3:0]                           we,
    input  logic [ADDRESS_BITWIDTH-1:0]          addr,
    input  logic [DATA_BITWIDTH-1:0]             din,
    output logic [DATA_BITWIDTH-1:0]             dout,
    output logic                                 rdy,
    output logic                                 bsy,
    output logic                                 br_cmd,
    output logic                                 br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0]        br_addr,
    output logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_wr_data,
    output logic [RAM_BURST_DATA_BITWIDTH/8-1:0] br_data_mask,
    input  logic [RAM_BURST_DATA_BITWIDTH-1:0]   br_rd_data,
    input  logic                                 br_rd_data_valid,
    input  logic                                 br_busy,
    output logic [31:0]                          hit_count,
    output logic [31:0]                          miss_count
);
    localparam int unsigned LINE_BITS = RAM_BURST_DATA_COUNT * RAM_BURST_DATA_BITWIDTH;
    localparam int unsigned WORD_BITS = $clog2(LINE_BITS / DATA_BITWIDTH);
    localparam int unsigned BEAT_BITS = $clog2(RAM_BURST_DATA_COUNT);
    localparam int unsigned LINES     = 1 << LINE_IX_BITWIDTH;
    localparam int unsigned TAG_LSB   = 2 + WORD_BITS + LINE_IX_BITWIDTH;
    localparam int unsigned TAG_BITS  = ADDRESS_BITWIDTH - TAG_LSB;

    typedef enum logic [2:0] {
        StIdle, StEvict, StEvictData, StFill, StFillWait, StRespond
    } state_e;

    state_e                      state_q;
    logic [LINE_BITS-1:0]        data_q [LINES];
    logic [TAG_BITS-1:0]         tag_q  [LINES];
    logic [LINES-1:0]            valid_q;
    logic [LINES-1:0]            dirty_q;
    logic [ADDRESS_BITWIDTH-3:0] req_waddr_q;
    logic [3:0]                  req_we_q;
    logic [DATA_BITWIDTH-1:0]    req_din_q;
    logic [BEAT_BITS-1:0]        beat_q;

    logic [WORD_BITS-1:0]               in_word, req_word;
    logic [LINE_IX_BITWIDTH-1:0]        in_idx, req_idx;
    logic [TAG_BITS-1:0]                in_tag, req_tag;
    logic                               in_hit, accept, last_beat;
    logic [DATA_BITWIDTH-1:0]           hit_word, req_word_val;
    logic [RAM_BURST_DATA_BITWIDTH-1:0] evict_beat;
    logic [RAM_DEPTH_BITWIDTH-1:0]      fill_addr, evict_addr;
    logic                               unused_addr_bits;

    // The byte offset is ignored: requests are word-aligned.
    assign unused_addr_bits = ^addr[1:0];

    assign in_word  = addr[2 +: WORD_BITS];
    assign in_idx   = addr[2 + WORD_BITS +: LINE_IX_BITWIDTH];
    assign in_tag   = addr[TAG_LSB +: TAG_BITS];
    assign req_word = req_waddr_q[0 +: WORD_BITS];
    assign req_idx  = req_waddr_q[WORD_BITS +: LINE_IX_BITWIDTH];
    assign req_tag  = req_waddr_q[WORD_BITS + LINE_IX_BITWIDTH +: TAG_BITS];

    assign in_hit    = valid_q[in_idx] && (tag_q[in_idx] == in_tag);
    assign accept    = (state_q == StIdle) && en;
    assign last_beat = (beat_q == BEAT_BITS'(RAM_BURST_DATA_COUNT - 1));

    assign hit_word     = data_q[in_idx][int'(in_word) * DATA_BITWIDTH +: DATA_BITWIDTH];
    assign req_word_val = data_q[req_idx][int'(req_word) * DATA_BITWIDTH +: DATA_BITWIDTH];
    assign evict_beat   = data_q[req_idx][int'(beat_q) * RAM_BURST_DATA_BITWIDTH
                                          +: RAM_BURST_DATA_BITWIDTH];

    // Burst start address is the line address scaled to RAM words.
    assign fill_addr  = RAM_DEPTH_BITWIDTH'({req_tag, req_idx, {BEAT_BITS{1'b0}}});
    assign evict_addr = RAM_DEPTH_BITWIDTH'({tag_q[req_idx], req_idx, {BEAT_BITS{1'b0}}});

    assign br_data_mask = '0;

    function automatic logic [DATA_BITWIDTH-1:0] merge_bytes(
        input logic [DATA_BITWIDTH-1:0] old_w,
        input logic [DATA_BITWIDTH-1:0] new_w,
        input logic [3:0]               be
    );
        merge_bytes = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merge_bytes[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    // Cache controller FSM: hits complete from IDLE, misses run evict/fill/respond.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            beat_q      <= '0;
            req_waddr_q <= '0;
            req_we_q    <= '0;
            req_din_q   <= '0;
            dout        <= '0;
            rdy         <= 1'b0;
            bsy         <= 1'b0;
            br_cmd      <= 1'b0;
            br_cmd_en   <= 1'b0;
            br_addr     <= '0;
            br_wr_data  <= '0;
            for (int i = 0; i < int'(LINES); i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            rdy       <= 1'b0;
            br_cmd_en <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        if (in_hit) begin
                            rdy <= 1'b1;
                            if (we == 4'b0000) begin
                                dout <= hit_word;
                            end else begin
                                data_q[in_idx][int'(in_word) * DATA_BITWIDTH +: DATA_BITWIDTH]
                                    <= merge_bytes(hit_word, din, we);
                                dirty_q[in_idx] <= 1'b1;
                            end
                        end else begin
                            req_waddr_q <= addr[ADDRESS_BITWIDTH-1:2];
                            req_we_q    <= we;
                            req_din_q   <= din;
                            bsy         <= 1'b1;
                            state_q     <= (valid_q[in_idx] && dirty_q[in_idx]) ? StEvict : StFill;
                        end
                    end
                end
                StEvict: begin
                    if (!br_busy) begin
                        br_cmd     <= 1'b1;
                        br_cmd_en  <= 1'b1;
                        br_addr    <= evict_addr;
                        br_wr_data <= evict_beat;
                        beat_q     <= beat_q + 1'b1;
                        state_q    <= StEvictData;
                    end
                end
                StEvictData: begin
                    br_wr_data <= evict_beat;
                    if (last_beat) begin
                        beat_q           <= '0;
                        dirty_q[req_idx] <= 1'b0;
                        state_q          <= StFill;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end
                StFill: begin
                    if (!br_busy) begin
                        br_cmd    <= 1'b0;
                        br_cmd_en <= 1'b1;
                        br_addr   <= fill_addr;
                        state_q   <= StFillWait;
                    end
                end
                StFillWait: begin
                    if (br_rd_data_valid) begin
                        data_q[req_idx][int'(beat_q) * RAM_BURST_DATA_BITWIDTH
                                        +: RAM_BURST_DATA_BITWIDTH] <= br_rd_data;
                        if (last_beat) begin
                            beat_q           <= '0;
                            tag_q[req_idx]   <= req_tag;
                            valid_q[req_idx] <= 1'b1;
                            state_q          <= StRespond;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                end
                StRespond: begin
                    if (req_we_q == 4'b0000) begin
                        dout <= req_word_val;
                    end else begin
                        data_q[req_idx][int'(req_word) * DATA_BITWIDTH +: DATA_BITWIDTH]
                            <= merge_bytes(req_word_val, req_din_q, req_we_q);
                        dirty_q[req_idx] <= 1'b1;
                    end
                    rdy     <= 1'b1;
                    bsy     <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BURST_CACHE_WB_STATS_EN
    // Count accepted requests by outcome; both counters wrap modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else if (accept) begin
            if (in_hit) hit_count  <= hit_count + 32'd1;
            else        miss_count <= miss_count + 32'd1;
        end
    end
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign hit_count     = '0;
    assign miss_count    = '0;
`endif

endmodule

// File: tb/tb_burst_cache_wb.sv
// Self-checking bench for burst_cache_wb: directed scenarios plus randomized traffic,
// checked against a flat word-memory model and a tag/valid/dirty directory per line.
module tb_burst_cache_wb;
    localparam int unsigned LIX   = 1;
    localparam int unsigned COUNT = 4;
    localparam int unsigned BW    = 64;
    localparam int unsigned NLINE = 1 << LIX;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rdy;
    logic        bsy;
    logic        br_cmd;
    logic        br_cmd_en;
    logic [7:0]  br_addr;
    logic [63:0] br_wr_data;
    logic [7:0]  br_data_mask;
    logic [63:0] br_rd_data;
    logic        br_rd_data_valid;
    logic        br_busy;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    burst_cache_wb #(
        .ADDRESS_BITWIDTH       (32),
        .DATA_BITWIDTH          (32),
        .LINE_IX_BITWIDTH       (LIX),
        .RAM_DEPTH_BITWIDTH     (8),
        .RAM_BURST_DATA_COUNT   (COUNT),
        .RAM_BURST_DATA_BITWIDTH(BW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .en              (en),
        .we              (we),
        .addr            (addr),
        .din             (din),
        .dout            (dout),
        .rdy             (rdy),
        .bsy             (bsy),
        .br_cmd          (br_cmd),
        .br_cmd_en       (br_cmd_en),
        .br_addr         (br_addr),
        .br_wr_data      (br_wr_data),
        .br_data_mask    (br_data_mask),
        .br_rd_data      (br_rd_data),
        .br_rd_data_valid(br_rd_data_valid),
        .br_busy         (br_busy),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Backing RAM (64-bit words) and the coherent CPU-visible memory (32-bit words).
    logic [63:0] ram  [256];
    logic [31:0] refw [512];
    // Directory model: which memory line each cache index holds.
    bit          m_valid [NLINE];
    bit          m_dirty [NLINE];
    int unsigned m_tag   [NLINE];
    int unsigned exp_hits = 0;
    int unsigned exp_miss = 0;

    // RAM-side bookkeeping.
    int          n_wr = 0;
    int          n_rd = 0;
    int          wr_left = 0;
    int          wr_ptr = 0;
    int          rd_left = 0;
    int          rd_ptr = 0;
    int          last_wr_addr = -1;
    int          last_rd_addr = -1;
    logic [63:0] ev_beat [COUNT];
    bit          busy_force = 0;
    bit          busy_drv = 0;
    bit          hold_rd = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] apply_we(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] w);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (w[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic check_counts();
`ifdef BURST_CACHE_WB_STATS_EN
        check_val("hit_count", hit_count, exp_hits);
        check_val("miss_count", miss_count, exp_miss);
`else
        check_val("hit_count", hit_count, 0);
        check_val("miss_count", miss_count, 0);
`endif
    endtask

    // BurstRAM model: captures write bursts, answers read bursts with random gaps,
    // injects spurious valids when idle, and randomly stalls with br_busy.
    initial begin
        br_busy = 1'b0;
        br_rd_data_valid = 1'b0;
        br_rd_data = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                wr_left = 0;
                rd_left = 0;
                br_rd_data_valid = 1'b0;
                busy_drv = 0;
                br_busy = 1'b0;
            end else begin
                if (wr_left > 0) begin
                    ev_beat[COUNT - wr_left] = br_wr_data;
                    check_val("evict_beat", br_wr_data, {refw[2*wr_ptr+1], refw[2*wr_ptr]});
                    ram[wr_ptr] = br_wr_data;
                    wr_ptr++;
                    wr_left--;
                end
                if (br_cmd_en) begin
                    check_val("cmd_while_busy", br_cmd_en & busy_drv, 0);
                    if (br_cmd) begin
                        n_wr++;
                        last_wr_addr = int'(br_addr);
                        ev_beat[0] = br_wr_data;
                        check_val("evict_beat", br_wr_data,
                                  {refw[2*int'(br_addr)+1], refw[2*int'(br_addr)]});
                        ram[br_addr] = br_wr_data;
                        wr_ptr = int'(br_addr) + 1;
                        wr_left = COUNT - 1;
                    end else begin
                        n_rd++;
                        last_rd_addr = int'(br_addr);
                        rd_ptr = int'(br_addr);
                        rd_left = COUNT;
                    end
                end
                br_rd_data_valid = 1'b0;
                if (rd_left > 0) begin
                    if (!hold_rd && ($urandom % 2 == 0)) begin
                        br_rd_data = ram[rd_ptr];
                        br_rd_data_valid = 1'b1;
                        rd_ptr++;
                        rd_left--;
                    end
                end else if ($urandom % 8 == 0) begin
                    br_rd_data = {$urandom, $urandom};
                    br_rd_data_valid = 1'b1;
                end
                busy_drv = busy_force || ($urandom % 4 == 0);
                br_busy = busy_drv;
            end
        end
    end

    // One CPU request; predicts hit/miss, burst traffic and data from the models.
    task automatic do_req(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
        int unsigned line, idx, tg, old_line;
        bit hit, ev;
        int wr0, rd0, n;
        line = a >> 5;
        idx = line % NLINE;
        tg = line / NLINE;
        hit = m_valid[idx] && (m_tag[idx] == tg);
        ev = !hit && m_valid[idx] && m_dirty[idx];
        old_line = m_tag[idx] * NLINE + idx;
        wr0 = n_wr;
        rd0 = n_rd;
        en = 1'b1;
        addr = a;
        we = w;
        din = d;
        @(negedge clk);
        en = 1'b0;
        if (hit) begin
            exp_hits++;
            check_val("hit_rdy", rdy, 1);
            check_val("hit_bsy", bsy, 0);
        end else begin
            exp_miss++;
            check_val("miss_bsy", bsy, 1);
            n = 0;
            while (!rdy && n < 600) begin
                // Requests while busy must be ignored.
                en = ($urandom % 3 == 0);
                addr = ($urandom % 2048) & ~32'd3;
                we = 4'($urandom);
                din = $urandom;
                @(negedge clk);
                n++;
                if (!rdy && !bsy) check_val("bsy_drop", bsy, 1);
            end
            en = 1'b0;
            check_val("miss_rdy", rdy, 1);
            check_val("miss_bsy_at_rdy", bsy, 0);
            check_val("wr_bursts", n_wr - wr0, ev ? 1 : 0);
            check_val("rd_bursts", n_rd - rd0, 1);
            check_val("fill_addr", last_rd_addr, (line * COUNT) % 256);
            if (ev) check_val("evict_addr", last_wr_addr, (old_line * COUNT) % 256);
        end
        if (w == 4'b0000) check_val("dout", dout, refw[a >> 2]);
        else refw[a >> 2] = apply_we(refw[a >> 2], d, w);
        m_valid[idx] = 1;
        m_tag[idx] = tg;
        if (w != 4'b0000) m_dirty[idx] = 1;
        else if (!hit) m_dirty[idx] = 0;
        check_counts();
    endtask

    task automatic rebuild_ref();
        for (int i = 0; i < 256; i++) begin
            refw[2*i]   = ram[i][31:0];
            refw[2*i+1] = ram[i][63:32];
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) ram[i] = {$urandom, $urandom};
        ram[0][63:32] = 32'h3F5A2E14;
        ram[4][31:0]  = 32'h2F5E3C7A;
        ram[5][31:0]  = 32'hC8F3E6A9;
        rebuild_ref();
        for (int i = 0; i < int'(NLINE); i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
            m_tag[i] = 0;
        end
        rst = 1'b1;
        en = 1'b0;
        we = '0;
        addr = '0;
        din = '0;
        repeat (3) @(negedge clk);
        check_val("rst_dout", dout, 0);
        check_val("rst_rdy", rdy, 0);
        check_val("rst_bsy", bsy, 0);
        check_val("rst_cmd", {br_cmd, br_cmd_en}, 0);
        check_val("rst_br_addr", br_addr, 0);
        check_val("rst_wr_data", br_wr_data, 0);
        check_val("rst_mask", br_data_mask, 0);
        check_counts();
        rst = 1'b0;
        @(negedge clk);

        // Cold read, then miss followed by a hit in the same line.
        do_req(32'd4, 4'b0000, 32'd0);
        check_val("cold4", dout, 32'h3F5A2E14);
        do_req(32'd32, 4'b0000, 32'd0);
        check_val("rd32", dout, 32'h2F5E3C7A);
        do_req(32'd40, 4'b0000, 32'd0);
        check_val("rd40", dout, 32'hC8F3E6A9);
        do_req(32'd40, 4'b0011, 32'h0000BEEF);
        do_req(32'd40, 4'b0000, 32'd0);
        check_val("rd40_merged", dout, 32'hC8F3BEEF);

        // Conflict miss evicts the dirty line, then the old line refills clean.
        do_req(32'd104, 4'b0000, 32'd0);
        check_val("evict_beat1_lo", ev_beat[1][31:0], 32'hC8F3BEEF);
        do_req(32'd40, 4'b0000, 32'd0);
        check_val("reread40", dout, 32'hC8F3BEEF);

        // Reset while the fill is waiting for beats.
        hold_rd = 1;
        n = n_rd;
        en = 1'b1;
        addr = 32'd200;
        we = 4'b0000;
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 100 && n_rd == n; i++) @(negedge clk);
        check_val("fill_started", n_rd - n, 1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst_async_bsy", bsy, 0);
        check_val("rst_async_rdy", rdy, 0);
        check_val("rst_async_cmd_en", br_cmd_en, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        hold_rd = 0;
        for (int i = 0; i < int'(NLINE); i++) begin
            m_valid[i] = 0;
            m_dirty[i] = 0;
        end
        rebuild_ref();
        exp_hits = 0;
        exp_miss = 0;
        check_counts();
        do_req(32'd4, 4'b0000, 32'd0);
        check_val("cold4_after_rst", dout, 32'h3F5A2E14);

        // Long br_busy stall on an evicting miss.
        do_req(32'd520, 4'b1111, 32'h12345678);
        busy_force = 1;
        fork
            do_req(32'd1024, 4'b0000, 32'd0);
            begin
                repeat (10) @(negedge clk);
                busy_force = 0;
            end
        join

        // Randomized traffic over eight lines sharing two indices.
        for (int k = 0; k < 250; k++) begin
            logic [31:0] a;
            logic [3:0] w;
            a = ($urandom % 8) * 32 + ($urandom % 8) * 4;
            w = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
            do_req(a, w, $urandom);
            if ($urandom % 5 == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/burst_cache_wb.md
Name: burst_cache_wb

Overview:
- Parametrised direct-mapped write-back data cache with a single CPU-side port.
- Sits between the CPU load/store unit and the BurstRAM controller.
- Successor to the write-through dual-port cache. Adds configurable line count and burst geometry, a dirty bit per line, and eviction of dirty lines via write bursts before each refill.

Parameters:
- ADDRESS_BITWIDTH, 32, CPU byte-address width.
- DATA_BITWIDTH, 32, CPU word width; fixed at 32, with 4 byte enables.
- LINE_IX_BITWIDTH, 2, log2 of the number of cache lines.
- RAM_DEPTH_BITWIDTH, 8, BurstRAM address width, in RAM words.
- RAM_BURST_DATA_COUNT, 4, RAM words per burst; one line equals one burst.
- RAM_BURST_DATA_BITWIDTH, 64, RAM word width; line = COUNT*BITWIDTH bits.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- en  in  1  request strobe; sampled only when bsy=0.
- we  in  4  byte write enables; 0 means read.
- addr  in  ADDRESS_BITWIDTH  byte address; word-aligned.
- din  in  32  write data.
- dout  out  32  read data; valid while rdy=1.
- rdy  out  1  one-cycle completion pulse.
- bsy  out  1  request in progress; new requests are ignored while high.
- br_cmd  out  1  0=read, 1=write.
- br_cmd_en  out  1  command strobe, one cycle.
- br_addr  out  RAM_DEPTH_BITWIDTH  burst start address, in RAM words.
- br_wr_data  out  RAM_BURST_DATA_BITWIDTH  write beat.
- br_data_mask  out  RAM_BURST_DATA_BITWIDTH/8  1=byte masked; always 0.
- br_rd_data  in  RAM_BURST_DATA_BITWIDTH  read beat.
- br_rd_data_valid  in  1  read beat valid.
- br_busy  in  1  RAM not ready for a command.
- hit_count  out  32  hit counter (see Optional Feature).
- miss_count  out  32  miss counter (see Optional Feature).

Behaviour:
- Address split, LSB first:
  - 2 byte-offset bits.
  - W word-in-line bits, where W = log2(COUNT*BITWIDTH/32).
  - LINE_IX_BITWIDTH index bits.
  - Remaining bits are the tag.
- br_addr = {tag, index, zeros(log2 COUNT)}, truncated to RAM_DEPTH_BITWIDTH.
- Reset: all valid and dirty bits cleared, FSM=IDLE. Outputs go to 0: dout, rdy, bsy, br_cmd, br_cmd_en, br_addr, br_wr_data, br_data_mask.
- States: IDLE, EVICT, EVICT_DATA, FILL, FILL_WAIT, RESPOND.
- IDLE, en=1:
  - Request is latched; the bench may drop en afterwards.
  - On a hit (valid and tag match):
    - read: dout=word, rdy=1 on the next cycle; bsy stays 0.
    - write: merge bytes selected by we, set dirty, rdy=1 next cycle.
    - Back-to-back hits sustain one request per cycle.
  - On a miss: bsy=1 next cycle.
    - Go to EVICT if the line is valid and dirty, otherwise FILL.
- EVICT: wait for br_busy=0, then assert for one cycle:
  - br_cmd=1, br_cmd_en=1;
  - br_addr = old tag and index;
  - br_wr_data = beat 0.
- EVICT_DATA: beats 1..COUNT-1 on consecutive cycles. Then clear dirty and go to FILL.
- FILL: wait for br_busy=0, then br_cmd=0 and br_cmd_en=1 for one cycle.
- FILL_WAIT:
  - Each br_rd_data_valid stores the next beat in order.
  - Beats may be non-consecutive.
  - After the last beat: tag written, valid=1, go to RESPOND.
- RESPOND:
  - Perform the latched read or write on the filled line; a write sets dirty.
  - rdy=1 and bsy=0 in the same cycle; return to IDLE.
- bsy=1 from the cycle after a miss is accepted through the cycle before rdy.
- rdy is never asserted together with bsy=1.
- en while bsy=1 is ignored, with no queueing.
- Partial write (we not all-ones) on a miss: still triggers a full fill, then the merge.
- rst mid-burst: FSM returns to IDLE immediately and all lines are invalidated. Dirty data is lost. br_cmd_en drops asynchronously.
- Spurious br_rd_data_valid outside FILL_WAIT is ignored.

Optional Feature:
- Macro: BURST_CACHE_WB_STATS_EN.
- Defined:
  - hit_count increments on each accepted hit; miss_count on each accepted miss.
  - Both are 32-bit, wrap modulo 2^32, and clear on rst.
- Undefined: both ports are tied to 0 and no counter flops are synthesised.

Test Plan:
- Setup: LINE_IX_BITWIDTH=1, COUNT=4, BITWIDTH=64, RAM.mem preloaded.
- Cold read addr 4 -> one read burst at br_addr 0, no write burst. dout=3F5A2E14 with rdy pulse; miss_count=1.
- Read addr 32, then addr 40 -> first a miss (dout=2F5E3C7A); second a hit one cycle after en, dout=C8F3E6A9, bsy never high. hit_count=1.
- Write addr 40 we=4'b0011 din=0000BEEF, then read 40 -> both hits; dout=C8F3BEEF.
- Read addr 104 (same index as 40, new tag):
  - First a write burst at br_addr 4 whose beat 1 has low half C8F3BEEF.
  - Then a read burst at br_addr 12.
  - Then rdy. Re-reading 40 misses with no eviction and returns C8F3BEEF.
- Assert rst during FILL_WAIT -> bsy=0 and rdy=0 immediately. A following read of 4 misses again (fresh fill, dout=3F5A2E14).
- Hold br_busy=1 for 10 cycles on a miss -> br_cmd_en is withheld until br_busy=0, with exactly one strobe per burst.
